// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard, RAW/WAW stall decision, stall counter and FSM.
// Optional macro HAZARD_BYPASS_EN lets a same-cycle writeback mask its pending bit in the hazard term.
module hazard_ctrl #(
    parameter int NREGS = 8,
    parameter int CNT_W = 8,
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             inst_valid_i,
    input  logic [RW-1:0]    s1_i,
    input  logic [RW-1:0]    s2_i,
    input  logic             s1_used_i,
    input  logic             s2_used_i,
    input  logic             wr_i,
    input  logic [RW-1:0]    dst_i,
    input  logic             wb_valid_i,
    input  logic [RW-1:0]    wb_dst_i,
    output logic             decode_next_o,
    output logic             issue_o,
    output logic [NREGS-1:0] pend_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    // Handshake: inst_valid_i is the request; issue_o is the accept, valid in the
    // same cycle. An instruction is consumed only when both are high at a posedge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] set_mask;
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard;
    logic             issue;

    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        for (int r = 0; r < NREGS; r++) begin
            wb_mask[r]  = wb_valid_i && (wb_dst_i == RW'(r));
            set_mask[r] = issue && wr_i && (dst_i == RW'(r));
        end
    end

`ifdef HAZARD_BYPASS_EN
    // A register being written back this cycle is already safe to read.
    assign pend_eff = pend & ~wb_mask;
`else
    assign pend_eff = pend;
`endif

    assign hazard = inst_valid_i &&
                    ((s1_used_i && pend_eff[s1_i]) ||
                     (s2_used_i && pend_eff[s2_i]) ||
                     (wr_i      && pend_eff[dst_i]));

    // Held low while reset is asserted, whatever the inputs do.
    assign issue = arstn && inst_valid_i && !hazard;

    assign issue_o       = issue;
    assign decode_next_o = issue;

    // Set wins over clear on the same register.
    assign pend_next = (pend & ~wb_mask) | set_mask;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = RUN;
                end else if (hazard) begin
                    state_next = STALL;
                end
            end
            RUN: begin
                if (hazard) begin
                    state_next = STALL;
                end else if (!inst_valid_i) begin
                    state_next = IDLE;
                end
            end
            STALL: begin
                if (issue) begin
                    state_next = RUN;
                end else if (!inst_valid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pend_o      = pend;
    assign stall_cnt_o = stall_cnt;
    assign state_o     = state;

endmodule
